// File: rtl/lif_neuron_nch_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Shared definitions for the N-channel leaky integrate-and-fire neuron:
//   - lif_state_e : FSM state encoding (INIT=0, RUN=1, REFR=2), also the
//                   encoding presented on state_out
//   - LEAK_SUB / LEAK_PROP : leak_mode encodings
//   - lif_sum_w() : width of the weighted synaptic sum that cannot overflow
// No ports (package).
// -----------------------------------------------------------------------------
package lif_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_REFR = 2'd2
  } lif_state_e;

  localparam logic LEAK_SUB  = 1'b0;
  localparam logic LEAK_PROP = 1'b1;

  // Each product is below 2^(in_w+w_w); n_ch of them sum below
  // 2^(in_w+w_w+clog2(n_ch)), so the sum never truncates.
  function automatic int lif_sum_w(input int n_ch, input int in_w, input int w_w);
    return in_w + w_w + $clog2(n_ch);
  endfunction

endpackage

// File: rtl/lif_neuron_nch_if.sv
// -----------------------------------------------------------------------------
// lif_neuron_nch_if
// Bundles the loader-side configuration/stimulus and the neuron outputs.
// Optional feature macro: SPIKE_CNT_EN (adds spike_count).
//   enable, params_ready          : advance qualifiers
//   chan_in, weight_in            : packed per-channel samples / weights
//   leak_mode, leak_config        : leak shape and rate
//   refr_period                   : refractory length in advance cycles
//   threshold_min, threshold_max  : adaptive threshold floor / ceiling
//   spike_out, v_mem_out,
//   threshold_out, state_out      : neuron outputs
//   spike_count (SPIKE_CNT_EN)    : saturating spike counter
// Modports: master drives the inputs, slave is the neuron.
// -----------------------------------------------------------------------------
interface lif_neuron_nch_if #(
  parameter int N_CH   = 4,
  parameter int IN_W   = 3,
  parameter int W_W    = 3,
  parameter int V_W    = 8,
  parameter int REFR_W = 4
);
  logic                   enable;
  logic                   params_ready;
  logic [N_CH*IN_W-1:0]   chan_in;
  logic [N_CH*W_W-1:0]    weight_in;
  logic                   leak_mode;
  logic [1:0]             leak_config;
  logic [REFR_W-1:0]      refr_period;
  logic [V_W-1:0]         threshold_min;
  logic [V_W-1:0]         threshold_max;
  logic                   spike_out;
  logic [V_W-1:0]         v_mem_out;
  logic [V_W-1:0]         threshold_out;
  logic [1:0]             state_out;
`ifdef SPIKE_CNT_EN
  logic [15:0]            spike_count;
`endif

  modport master (
    output enable, params_ready, chan_in, weight_in, leak_mode, leak_config,
           refr_period, threshold_min, threshold_max,
    input  spike_out, v_mem_out, threshold_out, state_out
`ifdef SPIKE_CNT_EN
         , spike_count
`endif
  );

  modport slave (
    input  enable, params_ready, chan_in, weight_in, leak_mode, leak_config,
           refr_period, threshold_min, threshold_max,
    output spike_out, v_mem_out, threshold_out, state_out
`ifdef SPIKE_CNT_EN
         , spike_count
`endif
  );

endinterface

// File: rtl/lif_neuron_nch_syn_sum.sv
// -----------------------------------------------------------------------------
// lif_syn_sum
// Combinational depression-adjusted weighted sum over N_CH channels:
//   sum = sum_i chan[i] * max(weight[i] - dep[i], 0)
// Ports:
//   chan_i   : packed channel samples, channel i at [i*IN_W +: IN_W]
//   weight_i : packed weights, channel i at [i*W_W +: W_W]
//   dep_i    : packed depression values, same packing as weight_i
//   sum_o    : full-precision weighted sum (SUM_W bits)
// -----------------------------------------------------------------------------
module lif_syn_sum
  import lif_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IN_W  = 3,
  parameter int W_W   = 3,
  parameter int SUM_W = lif_sum_w(N_CH, IN_W, W_W)
) (
  input  logic [N_CH*IN_W-1:0] chan_i,
  input  logic [N_CH*W_W-1:0]  weight_i,
  input  logic [N_CH*W_W-1:0]  dep_i,
  output logic [SUM_W-1:0]     sum_o
);

  logic [W_W-1:0]   eff_w [N_CH];
  logic [SUM_W-1:0] prod  [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [IN_W-1:0] c_g;
    logic [W_W-1:0]  w_g;
    logic [W_W-1:0]  d_g;

    assign c_g      = chan_i[g*IN_W +: IN_W];
    assign w_g      = weight_i[g*W_W +: W_W];
    assign d_g      = dep_i[g*W_W +: W_W];
    // Depression can exceed the weight; the effective weight floors at zero.
    assign eff_w[g] = (w_g > d_g) ? (w_g - d_g) : '0;
    assign prod[g]  = SUM_W'(c_g) * SUM_W'(eff_w[g]);
  end

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum_o = sum_o + prod[i];
    end
  end

endmodule

// File: rtl/lif_neuron_nch.sv
// -----------------------------------------------------------------------------
// lif_neuron_nch
// N-channel leaky integrate-and-fire neuron with adaptive threshold, synaptic
// depression, selectable subtractive/proportional leak and a programmable
// refractory period, sequenced by an INIT -> RUN <-> REFR FSM.
// Optional feature macro: SPIKE_CNT_EN (saturating 16-bit spike counter on
// bus.spike_count).
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : lif_neuron_nch_if.slave (config/stimulus in, spike/state out)
// -----------------------------------------------------------------------------
module lif_neuron_nch
  import lif_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int IN_W     = 3,
  parameter int W_W      = 3,
  parameter int V_W      = 8,
  parameter int REFR_W   = 4,
  parameter int THR_UP   = 4,
  parameter int THR_DN   = 1,
  parameter int DEP_STEP = 3
) (
  input  logic            clk,
  input  logic            reset,
  lif_neuron_nch_if.slave bus
);

  localparam int SUM_W  = lif_sum_w(N_CH, IN_W, W_W);
  // Two spare bits give headroom for v + sum overflow and the sign of v - leak.
  localparam int CALC_W = ((SUM_W > V_W) ? SUM_W : V_W) + 2;
  localparam int W_MAX  = (1 << W_W) - 1;
  localparam logic [W_W-1:0] DEP_LD = W_W'((DEP_STEP > W_MAX) ? W_MAX : DEP_STEP);
  localparam logic signed [CALC_W-1:0] V_MAX_S =
    $signed({{(CALC_W-V_W){1'b0}}, {V_W{1'b1}}});

  // Clamp a signed membrane candidate into [0, 2^V_W-1].
  function automatic logic [V_W-1:0] sat_v(input logic signed [CALC_W-1:0] x);
    if (x < 0)       return '0;
    if (x > V_MAX_S) return '1;
    return x[V_W-1:0];
  endfunction

  // min(t + THR_UP, ceil), evaluated one bit wider so it cannot wrap.
  function automatic logic [V_W-1:0] thr_inc(input logic [V_W-1:0] t,
                                             input logic [V_W-1:0] ceil);
    logic [V_W:0] s;
    s = {1'b0, t} + (V_W+1)'(THR_UP);
    return (s > {1'b0, ceil}) ? ceil : s[V_W-1:0];
  endfunction

  // max(t - THR_DN, floor) without wrap: compare against floor + THR_DN.
  function automatic logic [V_W-1:0] thr_dec(input logic [V_W-1:0] t,
                                             input logic [V_W-1:0] floor);
    logic [V_W:0] lim;
    lim = {1'b0, floor} + (V_W+1)'(THR_DN);
    return ({1'b0, t} < lim) ? floor : (t - V_W'(THR_DN));
  endfunction

  // Subtractive: leak_config+1. Proportional: max(1, v >> (leak_config+1)).
  function automatic logic [V_W-1:0] leak_amt(input logic mode,
                                              input logic [1:0] cfg,
                                              input logic [V_W-1:0] v);
    logic [2:0]     shamt;
    logic [V_W-1:0] prop;
    shamt = {1'b0, cfg} + 3'd1;
    prop  = v >> shamt;
    if (mode == LEAK_SUB) return V_W'(shamt);
    return (prop == '0) ? V_W'(1) : prop;
  endfunction

  lif_state_e            state_q, state_d;
  logic [V_W-1:0]        v_q, v_d;
  logic [V_W-1:0]        thr_q, thr_d;
  logic [REFR_W-1:0]     refr_q, refr_d;
  logic [N_CH*W_W-1:0]   dep_q, dep_d;
  logic                  spike_q, spike_d;
`ifdef SPIKE_CNT_EN
  logic [15:0]           cnt_q, cnt_d;
`endif

  logic                      adv;
  logic [SUM_W-1:0]          syn_sum;
  logic [V_W-1:0]            leak_v;
  logic [V_W-1:0]            thr_ceil;
  logic signed [CALC_W-1:0]  run_raw;
  logic signed [CALC_W-1:0]  refr_raw;
  logic [V_W-1:0]            run_v;
  logic [V_W-1:0]            refr_v;
  logic                      fire;

  lif_syn_sum #(
    .N_CH  (N_CH),
    .IN_W  (IN_W),
    .W_W   (W_W),
    .SUM_W (SUM_W)
  ) u_syn_sum (
    .chan_i   (bus.chan_in),
    .weight_i (bus.weight_in),
    .dep_i    (dep_q),
    .sum_o    (syn_sum)
  );

  assign adv      = bus.enable & bus.params_ready;
  assign leak_v   = leak_amt(bus.leak_mode, bus.leak_config, v_q);
  // A misordered min/max pair must not pull the ceiling below the floor.
  assign thr_ceil = (bus.threshold_max > bus.threshold_min) ? bus.threshold_max
                                                            : bus.threshold_min;
  assign run_raw  = $signed(CALC_W'(v_q)) + $signed(CALC_W'(syn_sum))
                  - $signed(CALC_W'(leak_v));
  assign refr_raw = $signed(CALC_W'(v_q)) - $signed(CALC_W'(leak_v));
  assign run_v    = sat_v(run_raw);
  assign refr_v   = sat_v(refr_raw);
  // Compared after clamping, so an overflowing sum still fires.
  assign fire     = (run_v >= thr_q);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    thr_d   = thr_q;
    refr_d  = refr_q;
    dep_d   = dep_q;
    spike_d = 1'b0;
`ifdef SPIKE_CNT_EN
    cnt_d   = cnt_q;
`endif
    if (adv) begin
      case (state_q)
        ST_INIT: begin
          thr_d   = bus.threshold_min;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (fire) begin
            spike_d = 1'b1;
            v_d     = '0;
            thr_d   = thr_inc(thr_q, thr_ceil);
            dep_d   = {N_CH{DEP_LD}};
`ifdef SPIKE_CNT_EN
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
            if (bus.refr_period != '0) begin
              refr_d  = bus.refr_period;
              state_d = ST_REFR;
            end
          end else begin
            v_d   = run_v;
            thr_d = thr_dec(thr_q, bus.threshold_min);
            for (int i = 0; i < N_CH; i++) begin
              if (dep_q[i*W_W +: W_W] != '0)
                dep_d[i*W_W +: W_W] = dep_q[i*W_W +: W_W] - W_W'(1);
            end
          end
        end
        ST_REFR: begin
          v_d    = refr_v;
          refr_d = refr_q - REFR_W'(1);
          // Leaving on the count of 1 makes REFR last exactly refr_period cycles.
          if (refr_q <= REFR_W'(1)) state_d = ST_RUN;
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      v_q     <= '0;
      thr_q   <= '0;
      refr_q  <= '0;
      dep_q   <= '0;
      spike_q <= 1'b0;
`ifdef SPIKE_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      thr_q   <= thr_d;
      refr_q  <= refr_d;
      dep_q   <= dep_d;
      spike_q <= spike_d;
`ifdef SPIKE_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.spike_out     = spike_q;
  assign bus.v_mem_out     = v_q;
  assign bus.threshold_out = thr_q;
  assign bus.state_out     = state_q;
`ifdef SPIKE_CNT_EN
  assign bus.spike_count   = cnt_q;
`endif

endmodule

// File: tb/tb_lif_neuron_nch.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_nch
// Directed + randomised stimulus for lif_neuron_nch at default parameters.
// A behavioural cycle model pushes expected outputs into a scoreboard queue
// as each step is driven; they are popped and compared after the clock edge.
// Honours SPIKE_CNT_EN when defined.
// -----------------------------------------------------------------------------
module tb_lif_neuron_nch;

  typedef struct packed {
    logic        spike;
    logic [7:0]  v;
    logic [7:0]  thr;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lif_neuron_nch_if #(.N_CH(4), .IN_W(3), .W_W(3), .V_W(8), .REFR_W(4)) bus_if ();

  lif_neuron_nch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Stimulus variables
  int         chan [4];
  int         wt   [4];
  logic       en, pr, lm;
  logic [1:0] lc;
  logic [3:0] refr;
  logic [7:0] tmin, tmax;

  // Model state
  int m_v, m_thr, m_refr, m_st, m_spike, m_cnt;
  int m_dep [4];

  exp_t sb_q [$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   s3_exp [6] = '{13, 21, 25, 27, 28, 28};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic apply();
    bus_if.enable        = en;
    bus_if.params_ready  = pr;
    bus_if.leak_mode     = lm;
    bus_if.leak_config   = lc;
    bus_if.refr_period   = refr;
    bus_if.threshold_min = tmin;
    bus_if.threshold_max = tmax;
    for (int i = 0; i < 4; i++) begin
      bus_if.chan_in[i*3 +: 3]   = 3'(chan[i]);
      bus_if.weight_in[i*3 +: 3] = 3'(wt[i]);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_thr = 0; m_refr = 0; m_st = 0; m_spike = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_dep[i] = 0;
  endtask

  task automatic model_step();
    int sum, leak, nv, ew, ceil_t, lci, sh;
    lci = int'(lc);
    if (!(en && pr)) begin
      m_spike = 0;
      return;
    end
    sh = m_v >> (lci + 1);
    leak = lm ? ((sh > 0) ? sh : 1) : (lci + 1);
    m_spike = 0;
    case (m_st)
      0: begin
        m_thr = int'(tmin);
        m_st  = 1;
      end
      1: begin
        sum = 0;
        for (int i = 0; i < 4; i++) begin
          ew = wt[i] - m_dep[i];
          if (ew < 0) ew = 0;
          sum += chan[i] * ew;
        end
        nv = m_v + sum - leak;
        if (nv < 0) nv = 0;
        if (nv > 255) nv = 255;
        if (nv >= m_thr) begin
          m_spike = 1;
          m_v = 0;
          ceil_t = (tmax > tmin) ? int'(tmax) : int'(tmin);
          m_thr = (m_thr + 4 > ceil_t) ? ceil_t : m_thr + 4;
          for (int i = 0; i < 4; i++) m_dep[i] = 3;
          if (m_cnt < 65535) m_cnt++;
          if (refr != 0) begin
            m_refr = int'(refr);
            m_st = 2;
          end
        end else begin
          m_v = nv;
          m_thr = (m_thr - 1 < int'(tmin)) ? int'(tmin) : m_thr - 1;
          for (int i = 0; i < 4; i++) if (m_dep[i] > 0) m_dep[i]--;
        end
      end
      default: begin
        m_v = (m_v - leak < 0) ? 0 : m_v - leak;
        if (m_refr == 1) m_st = 1;
        m_refr--;
      end
    endcase
  endtask

  task automatic step();
    exp_t e;
    apply();
    model_step();
    e.spike = m_spike[0];
    e.v     = 8'(m_v);
    e.thr   = 8'(m_thr);
    e.st    = 2'(m_st);
    e.cnt   = 16'(m_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("spike", 32'(bus_if.spike_out), 32'(e.spike));
    chk("v_mem", 32'(bus_if.v_mem_out), 32'(e.v));
    chk("thresh", 32'(bus_if.threshold_out), 32'(e.thr));
    chk("state", 32'(bus_if.state_out), 32'(e.st));
`ifdef SPIKE_CNT_EN
    chk("count", 32'(bus_if.spike_count), 32'(e.cnt));
`endif
  endtask

  // Asserts reset away from the clock edge and checks it acts without a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_spike", 32'(bus_if.spike_out), 32'd0);
    chk("rst_v", 32'(bus_if.v_mem_out), 32'd0);
    chk("rst_thr", 32'(bus_if.threshold_out), 32'd0);
    chk("rst_state", 32'(bus_if.state_out), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      chan[i] = 0;
      wt[i]   = 0;
    end
  endtask

  initial begin
    en = 1'b1; pr = 1'b1; lm = 1'b0; lc = 2'd0; refr = 4'd4;
    tmin = 8'd20; tmax = 8'd40;
    clear_inputs();
    apply();
    model_reset();
    #3;
    do_reset();

    // Scenario 1: INIT then idle RUN
    step();
    chk("s1_state", 32'(bus_if.state_out), 32'd1);
    chk("s1_thr", 32'(bus_if.threshold_out), 32'd20);
    repeat (3) step();
    chk("s1_v", 32'(bus_if.v_mem_out), 32'd0);

    // Scenario 2: spike, refractory, depressed second spike
    chan[0] = 7; wt[0] = 7;
    step();
    chk("s2_spike", 32'(bus_if.spike_out), 32'd1);
    chk("s2_thr", 32'(bus_if.threshold_out), 32'd24);
    chk("s2_v", 32'(bus_if.v_mem_out), 32'd0);
    chk("s2_state", 32'(bus_if.state_out), 32'd2);
    refr = 4'd2;  // mid-REFR change must not shorten the current period
    for (int k = 0; k < 4; k++) begin
      step();
      chk("s2_refr_state", 32'(bus_if.state_out), (k < 3) ? 32'd2 : 32'd1);
    end
    step();
    chk("s2_spike2", 32'(bus_if.spike_out), 32'd1);
    chk("s2_thr2", 32'(bus_if.threshold_out), 32'd28);
`ifdef SPIKE_CNT_EN
    chk("s2_count", 32'(bus_if.spike_count), 32'd2);
`endif

    // Scenario 5: reset mid-REFR (spike_out currently high), then freeze
    do_reset();
    step();
    chk("s5_init_thr", 32'(bus_if.threshold_out), 32'd20);
    chk("s5_init_v", 32'(bus_if.v_mem_out), 32'd0);
    chan[0] = 2; wt[0] = 7;
    step();
    chk("s5_v", 32'(bus_if.v_mem_out), 32'd13);
    en = 1'b0;
    repeat (5) begin
      step();
      chk("s5_frz_v", 32'(bus_if.v_mem_out), 32'd13);
      chk("s5_frz_spk", 32'(bus_if.spike_out), 32'd0);
    end
    en = 1'b1; pr = 1'b0;
    step();
    pr = 1'b1;

    // Scenario 3: proportional leak steady state
    do_reset();
    tmin = 8'd200; tmax = 8'd255; lm = 1'b1; lc = 2'd0;
    clear_inputs();
    chan[0] = 2; wt[0] = 7;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("s3_v", 32'(bus_if.v_mem_out), 32'(s3_exp[k]));
      chk("s3_spk", 32'(bus_if.spike_out), 32'd0);
    end

    // Scenario 4: overflow clamp and threshold ceiling
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chan[i] = 7;
      wt[i]   = 7;
    end
    tmin = 8'd250; tmax = 8'd255; lm = 1'b0; lc = 2'd0; refr = 4'd0;
    step();
    step();
    chk("s4_v", 32'(bus_if.v_mem_out), 32'd195);
    step();
    chk("s4_spike", 32'(bus_if.spike_out), 32'd1);
    chk("s4_thr", 32'(bus_if.threshold_out), 32'd254);
    repeat (3) step();
    chk("s4_spike_ceil", 32'(bus_if.spike_out), 32'd1);
    chk("s4_thr_ceil", 32'(bus_if.threshold_out), 32'd255);

    // Randomised mix against the model
    repeat (60) begin
      for (int i = 0; i < 4; i++) begin
        chan[i] = $urandom_range(0, 7);
        wt[i]   = $urandom_range(0, 7);
      end
      en   = ($urandom_range(0, 7) != 0);
      pr   = ($urandom_range(0, 7) != 0);
      lm   = 1'($urandom_range(0, 1));
      lc   = 2'($urandom_range(0, 3));
      refr = 4'($urandom_range(0, 3));
      tmin = 8'($urandom_range(10, 120));
      tmax = 8'($urandom_range(0, 255));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
